// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port arbiter: default sizing and FSM encoding.
package fifo_arb_pkg;
   localparam int NUM_REQ_D    = 4;
   localparam int DATA_WIDTH_D = 8;
   localparam int BUF_WIDTH_D  = 3;
   localparam int MAX_BURST_D  = 4;
   localparam int DEPTH        = 1 << BUF_WIDTH_D;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_t;
endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Rotate-priority select: first asserted request at or after i_ptr, wrapping modulo N.
module rr_picker #(
   parameter  int N  = 4,
   localparam int PW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [PW-1:0] i_ptr,
   output logic [PW-1:0] o_idx,
   output logic          o_valid
);
   always_comb begin
      o_idx   = '0;
      o_valid = 1'b0;
      // Walk from farthest to nearest so the closest hit overwrites earlier ones.
      for (int k = N - 1; k >= 0; k--) begin
         int j;
         j = int'(i_ptr) + k;
         if (j >= N) j = j - N;
         if (i_req[j]) begin
            o_idx   = PW'(j);
            o_valid = 1'b1;
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one Sync_FIFO write port between NUM_REQ producers.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter  int NUM_REQ    = NUM_REQ_D,
   parameter  int DATA_WIDTH = DATA_WIDTH_D,
   parameter  int BUF_WIDTH  = BUF_WIDTH_D,
   parameter  int MAX_BURST  = MAX_BURST_D,
   localparam int PW         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic [NUM_REQ-1:0]            i_req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
   output logic [NUM_REQ-1:0]            o_ack,
   input  logic [BUF_WIDTH:0]            i_fifo_counter,
   input  logic                          i_fifo_buf_full,
   output logic                          o_fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         o_fifo_buf_in,
   output logic [PW-1:0]                 o_owner,
   output logic                          o_busy,
   output logic [PW-1:0]                 o_rr_ptr
);
   localparam int QDEPTH = 1 << BUF_WIDTH;
   localparam int CW     = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
   localparam int OW     = BUF_WIDTH + 2;

   arb_state_t            r_state, w_next;
   logic [PW-1:0]         r_owner, r_rr_ptr;
   logic [CW-1:0]         r_burst_cnt;
   logic                  r_wr_en;
   logic [DATA_WIDTH-1:0] r_buf_in;

   logic [PW-1:0]         w_pick_idx;
   logic                  w_pick_valid;
   logic [OW-1:0]         w_occ;
   logic                  w_space_ok, w_own_req, w_accept, w_last;

   rr_picker #(.N(NUM_REQ)) u_pick (
      .i_req   (i_req),
      .i_ptr   (r_rr_ptr),
      .o_idx   (w_pick_idx),
      .o_valid (w_pick_valid)
   );

   // The write already in flight counts as occupied; concurrent reads are ignored.
   assign w_occ      = {1'b0, i_fifo_counter} + OW'(r_wr_en);
   assign w_space_ok = !i_fifo_buf_full && (w_occ < OW'(QDEPTH));
   assign w_own_req  = i_req[r_owner];
   assign w_accept   = (r_state == BURST) && w_own_req && w_space_ok;
   assign w_last     = (r_burst_cnt == CW'(MAX_BURST - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_pick_valid && w_space_ok) w_next = BURST;
         BURST:   if (!w_own_req || !w_space_ok || (w_accept && w_last)) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Ack is suppressed during reset since the registered write is dropped.
   always_comb begin
      o_ack  = '0;
      o_busy = (r_state == BURST);
      if (w_accept && !i_rst) o_ack[r_owner] = 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
         r_wr_en     <= 1'b0;
         r_buf_in    <= '0;
      end else begin
         r_wr_en <= w_accept;
         if (w_accept) begin
            r_buf_in    <= i_req_data[r_owner*DATA_WIDTH +: DATA_WIDTH];
            r_burst_cnt <= r_burst_cnt + 1'b1;
         end
         if (r_state == IDLE && w_next == BURST) begin
            r_owner     <= w_pick_idx;
            r_burst_cnt <= '0;
         end
         if (r_state == BURST && w_next == IDLE)
            r_rr_ptr <= (r_owner == PW'(NUM_REQ - 1)) ? '0 : r_owner + 1'b1;
      end
   end

   assign o_fifo_wr_en  = r_wr_en;
   assign o_fifo_buf_in = r_buf_in;
   assign o_owner       = r_owner;
   assign o_rr_ptr      = r_rr_ptr;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus round-robin burst sequences.
module tb_fifo_wr_arbiter;
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic [3:0]  fifo_counter;
   logic        fifo_buf_full;
   logic        fifo_wr_en;
   logic [7:0]  fifo_buf_in;
   logic [1:0]  owner;
   logic        busy;
   logic [1:0]  rr_ptr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fifo_wr_arbiter dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_req           (req),
      .i_req_data      (req_data),
      .o_ack           (ack),
      .i_fifo_counter  (fifo_counter),
      .i_fifo_buf_full (fifo_buf_full),
      .o_fifo_wr_en    (fifo_wr_en),
      .o_fifo_buf_in   (fifo_buf_in),
      .o_owner         (owner),
      .o_busy          (busy),
      .o_rr_ptr        (rr_ptr)
   );

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [7:0] d;
      logic [3:0] cnt;
      logic       full;
      logic [3:0] ack;
      logic       wr;
      logic [7:0] bin;
      logic [1:0] own;
      logic       busy;
      logic [1:0] rr;
   } vec_t;

   vec_t tv[24];

   function automatic vec_t mk(input logic r, input logic [3:0] q, input logic [7:0] d,
                               input logic [3:0] c, input logic f, input logic [3:0] a,
                               input logic w, input logic [7:0] b, input logic [1:0] o,
                               input logic bs, input logic [1:0] p);
      vec_t v;
      v.rst = r; v.req = q; v.d = d; v.cnt = c; v.full = f;
      v.ack = a; v.wr = w; v.bin = b; v.own = o; v.busy = bs; v.rr = p;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d] got %0h want %0h", nm, idx, act, exp);
      end
   endtask

   // Reset, then hold mask for nb bursts; each burst is 1 arbitration cycle + 4 writes.
   task automatic run_pattern(input string nm, input logic [3:0] mask, input int nb);
      int         own = 0;
      int         ptr = 0;
      int         ph;
      logic       ew = 1'b0;
      logic [7:0] eb = 8'h00;
      @(negedge clk);
      rst = 1'b1; req = mask; fifo_counter = '0; fifo_buf_full = 1'b0;
      for (int t = 0; t < nb * 5; t++) begin
         @(negedge clk);
         rst = 1'b0;
         for (int p = 0; p < 4; p++) req_data[p*8 +: 8] = 8'(p * 64 + t);
         #1;
         ph = t % 5;
         if (ph == 0) begin
            own = ptr;
            while (!mask[own]) own = (own + 1) % 4;
         end
         chk({nm, "_ack"}, t, 32'(ack), (ph != 0) ? 32'(1 << own) : 32'd0);
         chk({nm, "_busy"}, t, 32'(busy), 32'(ph != 0));
         chk({nm, "_wr"}, t, 32'(fifo_wr_en), 32'(ew));
         chk({nm, "_buf"}, t, 32'(fifo_buf_in), 32'(eb));
         if (ph != 0) chk({nm, "_own"}, t, 32'(owner), 32'(own));
         ew = (ph != 0);
         if (ph != 0) eb = 8'(own * 64 + t);
         if (ph == 4) ptr = (own + 1) % 4;
      end
   endtask

   initial begin
      tv[0]  = mk(1, 4'hF, 8'd0,  4'd0, 0, 4'h0, 0, 8'h00, 2'd0, 0, 2'd0);
      tv[1]  = mk(1, 4'hF, 8'd0,  4'd0, 0, 4'h0, 0, 8'h00, 2'd0, 0, 2'd0);
      tv[2]  = mk(0, 4'h4, 8'd10, 4'd0, 0, 4'h0, 0, 8'h00, 2'd0, 0, 2'd0);
      tv[3]  = mk(0, 4'h4, 8'd10, 4'd0, 0, 4'h4, 0, 8'h00, 2'd2, 1, 2'd0);
      tv[4]  = mk(0, 4'h4, 8'd20, 4'd0, 0, 4'h4, 1, 8'd10,  2'd2, 1, 2'd0);
      tv[5]  = mk(0, 4'h4, 8'd30, 4'd0, 0, 4'h4, 1, 8'd20,  2'd2, 1, 2'd0);
      tv[6]  = mk(0, 4'h0, 8'd30, 4'd0, 0, 4'h0, 1, 8'd30,  2'd2, 1, 2'd0);
      tv[7]  = mk(0, 4'h0, 8'd30, 4'd0, 0, 4'h0, 0, 8'd30,  2'd2, 0, 2'd3);
      tv[8]  = mk(0, 4'h3, 8'h55, 4'd7, 0, 4'h0, 0, 8'd30,  2'd2, 0, 2'd3);
      tv[9]  = mk(0, 4'h3, 8'h55, 4'd7, 0, 4'h1, 0, 8'd30,  2'd0, 1, 2'd3);
      tv[10] = mk(0, 4'h3, 8'h55, 4'd7, 0, 4'h0, 1, 8'h55, 2'd0, 1, 2'd3);
      tv[11] = mk(0, 4'h3, 8'h55, 4'd8, 1, 4'h0, 0, 8'h55, 2'd0, 0, 2'd1);
      tv[12] = mk(0, 4'h3, 8'h55, 4'd8, 1, 4'h0, 0, 8'h55, 2'd0, 0, 2'd1);
      tv[13] = mk(0, 4'h3, 8'h66, 4'd7, 0, 4'h0, 0, 8'h55, 2'd0, 0, 2'd1);
      tv[14] = mk(0, 4'h3, 8'h66, 4'd7, 0, 4'h2, 0, 8'h55, 2'd1, 1, 2'd1);
      tv[15] = mk(0, 4'h0, 8'h66, 4'd7, 0, 4'h0, 1, 8'h66, 2'd1, 1, 2'd1);
      tv[16] = mk(0, 4'h0, 8'h66, 4'd0, 0, 4'h0, 0, 8'h66, 2'd1, 0, 2'd2);
      tv[17] = mk(0, 4'h8, 8'hA1, 4'd0, 0, 4'h0, 0, 8'h66, 2'd1, 0, 2'd2);
      tv[18] = mk(0, 4'h8, 8'hA1, 4'd0, 0, 4'h8, 0, 8'h66, 2'd3, 1, 2'd2);
      tv[19] = mk(1, 4'h8, 8'hA2, 4'd0, 0, 4'h0, 1, 8'hA1, 2'd3, 1, 2'd2);
      tv[20] = mk(0, 4'h9, 8'h0B, 4'd0, 0, 4'h0, 0, 8'h00, 2'd0, 0, 2'd0);
      tv[21] = mk(0, 4'h9, 8'h0B, 4'd0, 0, 4'h1, 0, 8'h00, 2'd0, 1, 2'd0);
      tv[22] = mk(0, 4'h0, 8'h0B, 4'd0, 0, 4'h0, 1, 8'h0B, 2'd0, 1, 2'd0);
      tv[23] = mk(0, 4'h0, 8'h0B, 4'd0, 0, 4'h0, 0, 8'h0B, 2'd0, 0, 2'd1);

      rst = 1'b1; req = 4'hF; req_data = '0; fifo_counter = '0; fifo_buf_full = 1'b0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         rst           = tv[i].rst;
         req           = tv[i].req;
         req_data      = {4{tv[i].d}};
         fifo_counter  = tv[i].cnt;
         fifo_buf_full = tv[i].full;
         #1;
         chk("ack",  i, 32'(ack),         32'(tv[i].ack));
         chk("wr",   i, 32'(fifo_wr_en),  32'(tv[i].wr));
         chk("buf",  i, 32'(fifo_buf_in), 32'(tv[i].bin));
         chk("own",  i, 32'(owner),       32'(tv[i].own));
         chk("busy", i, 32'(busy),        32'(tv[i].busy));
         chk("rr",   i, 32'(rr_ptr),      32'(tv[i].rr));
      end

      run_pattern("fair", 4'hF, 5);
      run_pattern("cap",  4'h2, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
